// File: rtl/pulse_train_seq.sv
// Pulse-train sequencer: turns one host command into a series of single-pulse
// requests for the DAC pulse stage, stepping the amplitude with saturation between pulses.
module pulse_train_seq #(
  parameter int CNT_1US = 50,
  parameter int NUM_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             chan,
  input  logic [11:0]      amp_init,
  input  logic [11:0]      amp_step,
  input  logic             step_dn,
  input  logic [NUM_W-1:0] num,
  input  logic [31:0]      wid,
  input  logic [31:0]      gap,
  output logic             da_start,
  output logic             da_chan,
  output logic [11:0]      da_amp,
  output logic [31:0]      da_wid,
  input  logic             da_done,
  output logic             busy,
  output logic [NUM_W-1:0] pulse_idx,
  output logic             done,
  output logic             aborted
);

  localparam int               DIV_W    = (CNT_1US > 1) ? $clog2(CNT_1US) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CNT_1US - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, PULSE, GAP} state_t;

  state_t           state;
  logic [11:0]      step_r;
  logic             dn_r;
  logic [NUM_W-1:0] last_idx_r;
  logic [31:0]      gap_r;
  logic             abort_pend;
  logic [DIV_W-1:0] div_cnt;
  logic [31:0]      us_cnt;
  logic             gap_end;

  // 13-bit step; bit 12 flags overflow (add) or borrow (subtract).
  function automatic logic [11:0] amp_next(input logic [11:0] amp,
                                           input logic [11:0] step,
                                           input logic        dn);
    logic [12:0] acc;
    if (dn) begin
      acc      = {1'b0, amp} - {1'b0, step};
      amp_next = acc[12] ? 12'd0 : acc[11:0];
    end else begin
      acc      = {1'b0, amp} + {1'b0, step};
      amp_next = acc[12] ? 12'hFFF : acc[11:0];
    end
  endfunction

  // A zero gap still spends one turnaround cycle in GAP before the next request.
  assign gap_end = (gap_r == 32'd0) ||
                   ((div_cnt == DIV_LAST) && (us_cnt == gap_r - 32'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      da_start   <= 1'b0;
      da_chan    <= 1'b0;
      da_amp     <= 12'd0;
      da_wid     <= 32'd0;
      busy       <= 1'b0;
      pulse_idx  <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      step_r     <= 12'd0;
      dn_r       <= 1'b0;
      last_idx_r <= '0;
      gap_r      <= 32'd0;
      abort_pend <= 1'b0;
      div_cnt    <= '0;
      us_cnt     <= 32'd0;
    end else begin
      da_start <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (num != '0) begin
              da_chan    <= chan;
              da_amp     <= amp_init;
              da_wid     <= wid;
              step_r     <= amp_step;
              dn_r       <= step_dn;
              last_idx_r <= num - NUM_W'(1);
              gap_r      <= gap;
              pulse_idx  <= '0;
              abort_pend <= 1'b0;
              busy       <= 1'b1;
              da_start   <= 1'b1;
              state      <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= IDLE;
          end else begin
            state <= PULSE;
          end
        end
        PULSE: begin
          // An abort here waits for the in-flight pulse so the DAC returns to zero.
          if (abort) abort_pend <= 1'b1;
          if (da_done) begin
            if (pulse_idx == last_idx_r) begin
              busy       <= 1'b0;
              done       <= 1'b1;
              abort_pend <= 1'b0;
              state      <= IDLE;
            end else if (abort || abort_pend) begin
              busy       <= 1'b0;
              done       <= 1'b1;
              aborted    <= 1'b1;
              abort_pend <= 1'b0;
              state      <= IDLE;
            end else begin
              pulse_idx <= pulse_idx + NUM_W'(1);
              da_amp    <= amp_next(da_amp, step_r, dn_r);
              state     <= GAP;
            end
          end
        end
        GAP: begin
          if (abort) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            div_cnt <= '0;
            us_cnt  <= 32'd0;
            state   <= IDLE;
          end else if (gap_end) begin
            div_cnt  <= '0;
            us_cnt   <= 32'd0;
            da_start <= 1'b1;
            state    <= ISSUE;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            us_cnt  <= us_cnt + 32'd1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
